slc3_sram_model: RTL and testbench
==================================

# slc3_sram_model

Synchronous on-chip word memory that sits directly below the SLC-3 memory interface: it consumes `ADDR`, `OE`, `WE` and `Data_to_SRAM`, and returns `Data_from_SRAM` to the Mem2IO path. After reset it runs a self-load sequence: it copies a fixed program image into the low words and zero-fills the rest, so the CPU always starts from a known memory state. An optional write-protect window guards the loaded program area.

## Interface
Parameters:
- `ADDR_W`, default 10: array address width; `DEPTH = 2**ADDR_W` words.
- `INIT_WORDS`, default 32: number of words taken from the program image; must be ≤ DEPTH.
- `PROTECT_LIMIT`, default 32: words `[0, PROTECT_LIMIT)` are write-protected. Used only when the protect feature is compiled in.

Ports:
- `Clk`, input, 1: the single clock. All state changes on its rising edge.
- `Reset`, input, 1: synchronous, active-low reset.
- `ADDR`, input, 16: word address from the CPU's MAR.
- `OE`, input, 1: active-low read enable.
- `WE`, input, 1: active-low write enable.
- `Data_to_SRAM`, input, 16: write data.
- `Data_from_SRAM`, output, 16: registered read data.
- `init_busy`, output, 1: high while the self-load is running.
- `init_done`, output, 1: high once the self-load has finished; remains high until the next reset.
- `wp_violation`, output, 1: sticky flag for a write attempt into the protected window.

## Operation
- Storage is `DEPTH` × 16 bits.
- **In range:** `ADDR[15:ADDR_W] == 0`. Any other address is out of range.
- **Out-of-range read:** captures 0x0000.
- **Out-of-range write:** ignored, with no flag raised.
- **State machine:** three states, `S_RESET`, `S_INIT` and `S_READY`.
- **S_RESET:**
  - Entered whenever `Reset` is low at a clock edge, from any state, including mid-init.
  - Clears the load counter, `Data_from_SRAM`, `init_done` and `wp_violation`.
  - Moves to `S_INIT` on the first edge with `Reset` high.
- **S_INIT:**
  - Each cycle writes word `cnt`: image word if `cnt < INIT_WORDS`, otherwise 0x0000. Then `cnt` increments.
  - At `cnt == DEPTH-1` it writes the last word and moves to `S_READY`.
  - CPU `OE`/`WE` are ignored and `Data_from_SRAM` holds 0x0000.
- **S_READY:**
  - **Read** (`OE=0`, `WE=1`): captures `mem[ADDR[ADDR_W-1:0]]` into `Data_from_SRAM`.
  - **Write** (`WE=0`): stores `Data_to_SRAM`. Write wins when `OE` and `WE` are both low, and `Data_from_SRAM` then holds its previous value.
  - **Idle** (`OE=1`, `WE=1`): `Data_from_SRAM` holds.
- **Read during a write cycle:** a read of an address written in the previous cycle returns the new data. There is no same-cycle bypass, because a read and a write never coincide.
- Memory-mapped I/O (0xFFFF) is handled upstream. Such addresses reach this block as out-of-range and are treated as above.

## Timing
- **Reset values:** `Data_from_SRAM=0x0000`, `init_busy=0` while in `S_RESET`, `init_done=0`, `wp_violation=0`.
- **`init_busy`:** high for exactly `DEPTH` cycles, starting the cycle after `Reset` rises.
- **`init_done`:** rises on the same edge at which `init_busy` falls.
- **Read latency:** 1 cycle. The address is presented with `OE=0` at edge N, and data is valid after edge N and stable until the next read.
- **Write:** takes effect at the edge where `WE=0` is sampled.
- **Reset mid-init:** the load restarts from word 0, and words already written are rewritten.
- **Reset in S_READY:** the entire memory is reloaded, and CPU-written data is lost.

## Configuration
- **Macro:** `SLC3_SRAM_WRITE_PROTECT_EN`.
- **Defined:**
  - In `S_READY`, a write with an in-range `ADDR < PROTECT_LIMIT` is discarded.
  - `wp_violation` is set on the following edge and stays set until reset.
  - The init sequence ignores protection.
- **Undefined:**
  - All in-range words are writable.
  - `wp_violation` is tied to 0.
  - The `PROTECT_LIMIT` parameter is unused.

## Structure
- **Shared package `slc3_mem_pkg`:**
  - State enum `sram_state_t` (`S_RESET`, `S_INIT`, `S_READY`).
  - Constant `IMAGE_MAX = 64`.
  - Constant array `PROGRAM_IMAGE[IMAGE_MAX]` of 16-bit words, with `PROGRAM_IMAGE[0]=16'h5020` and `[1]=16'h1021`.
  - Default-value constants for `ADDR_W` and `INIT_WORDS`.
- **Sub-module `slc3_mem_image_rom`:**
  - Combinational lookup of the load word for a given index.
  - Returns `PROGRAM_IMAGE[idx]` when `idx < INIT_WORDS`, otherwise 0x0000.
  - Keeps the init FSM free of image data.

## Test plan
- **Reset and init:** Release `Reset` and count cycles. Required: `init_busy` high for exactly 1024 cycles (default `ADDR_W=10`), then `init_done=1`, with `Data_from_SRAM=0x0000` throughout.
- **Image read-back:** After init, drive `ADDR=0x0000`, `OE=0`. Required: one cycle later `Data_from_SRAM=0x5020`. Then `ADDR=0x0001` gives 0x1021, and `ADDR=0x0100` gives 0x0000.
- **Write then read:** Write 0xBEEF to 0x0040, then read 0x0040. Required: 0xBEEF. Also drive `OE=0`, `WE=0` together at 0x0041 with 0x1234. Required: `Data_from_SRAM` unchanged, and a later read of 0x0041 returns 0x1234.
- **Out-of-range:** Write 0xAAAA to 0xFFFF, then read 0xFFFF. Required: 0x0000, and a read of 0x03FF is unaffected.
- **Write protect (macro defined):** Write 0xDEAD to 0x0005. Required: `wp_violation=1` next cycle, and a read of 0x0005 still returns the image value. A write to 0x0020 succeeds.
- **Reset mid-init:** Assert `Reset` low at init cycle 500, then release. Required: `init_busy` restarts, runs a full 1024 cycles, and the image is intact afterward.

Source files
------------

// File: rtl/slc3_mem_pkg.sv
// Shared types and the boot program image for the SLC-3 on-chip SRAM model.
package slc3_mem_pkg;

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_INIT  = 2'd1,
    S_READY = 2'd2
  } sram_state_t;

  localparam int ADDR_W_DEF     = 10;
  localparam int INIT_WORDS_DEF = 32;
  localparam int IMAGE_MAX      = 64;
  localparam int IMAGE_AW       = 6;

  // Words 32..63 are only loaded when INIT_WORDS is raised past the default.
  localparam logic [15:0] PROGRAM_IMAGE [IMAGE_MAX] = '{
    16'h5020, 16'h1021, 16'h1021, 16'h0BFE, 16'h3200, 16'h2201, 16'hF025, 16'h0000,
    16'h1222, 16'h1DBF, 16'h6180, 16'h7181, 16'h9FFF, 16'h5A47, 16'h0401, 16'h0E03,
    16'h3001, 16'h4002, 16'hA003, 16'hB004, 16'hC1C0, 16'hD005, 16'hE006, 16'hF021,
    16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 16'h0F0F, 16'hF0F0, 16'h55AA, 16'hAA55,
    16'hDEAD, 16'hBEEF, 16'hCAFE, 16'hF00D, 16'h1111, 16'h2222, 16'h3333, 16'h4444,
    16'h5555, 16'h6666, 16'h7777, 16'h8888, 16'h9999, 16'hAAAA, 16'hBBBB, 16'hCCCC,
    16'h0102, 16'h0304, 16'h0506, 16'h0708, 16'h090A, 16'h0B0C, 16'h0D0E, 16'h0F10,
    16'hFEDC, 16'hBA98, 16'h7654, 16'h3210, 16'hA5A5, 16'h5A5A, 16'hC3C3, 16'h3C3C
  };

endpackage

// File: rtl/slc3_mem_image_rom.sv
// Combinational lookup of the self-load word for a given memory index.
module slc3_mem_image_rom
  import slc3_mem_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int INIT_WORDS = INIT_WORDS_DEF
) (
  input  logic [ADDR_W-1:0] idx,
  output logic [15:0]       word
);

  logic [IMAGE_AW-1:0] sel;

  always_comb begin
    sel  = IMAGE_AW'(idx);
    word = 16'h0000;
    // Guard against IMAGE_MAX too, so an oversized INIT_WORDS zero-fills.
    if (int'(idx) < INIT_WORDS && int'(idx) < IMAGE_MAX)
      word = PROGRAM_IMAGE[sel];
  end

endmodule

// File: rtl/slc3_sram_model.sv
// SLC-3 on-chip word SRAM with post-reset self-load.
// Optional write-protect window enabled by SLC3_SRAM_WRITE_PROTECT_EN.
module slc3_sram_model
  import slc3_mem_pkg::*;
#(
  parameter int ADDR_W        = ADDR_W_DEF,
  parameter int INIT_WORDS    = INIT_WORDS_DEF,
  parameter int PROTECT_LIMIT = 32
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [15:0] ADDR,
  input  logic        OE,
  input  logic        WE,
  input  logic [15:0] Data_to_SRAM,
  output logic [15:0] Data_from_SRAM,
  output logic        init_busy,
  output logic        init_done,
  output logic        wp_violation
);

  localparam int DEPTH = 2**ADDR_W;

`ifdef SLC3_SRAM_WRITE_PROTECT_EN
  localparam bit WP_EN = 1'b1;
`else
  localparam bit WP_EN = 1'b0;
`endif

  sram_state_t       state;
  logic [ADDR_W-1:0] cnt;
  logic [15:0]       mem [DEPTH];
  logic [15:0]       rom_word;
  logic              in_range, wr_prot, cpu_wr;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;

  slc3_mem_image_rom #(
    .ADDR_W     (ADDR_W),
    .INIT_WORDS (INIT_WORDS)
  ) u_rom (
    .idx  (cnt),
    .word (rom_word)
  );

  always_comb begin
    in_range  = (ADDR >> ADDR_W) == 16'd0;
    wr_prot   = WP_EN && in_range && (int'({16'd0, ADDR}) < PROTECT_LIMIT);
    cpu_wr    = (state == S_READY) && !WE && in_range && !wr_prot;
    // One write port shared by the loader and the CPU; they never overlap.
    mem_we    = Reset && ((state == S_INIT) || cpu_wr);
    mem_addr  = (state == S_INIT) ? cnt : ADDR[ADDR_W-1:0];
    mem_wdata = (state == S_INIT) ? rom_word : Data_to_SRAM;
  end

  always_ff @(posedge Clk) begin
    if (mem_we)
      mem[mem_addr] <= mem_wdata;
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state          <= S_RESET;
      cnt            <= '0;
      Data_from_SRAM <= 16'h0000;
      init_busy      <= 1'b0;
      init_done      <= 1'b0;
      wp_violation   <= 1'b0;
    end else begin
      case (state)
        S_RESET: begin
          state     <= S_INIT;
          cnt       <= '0;
          init_busy <= 1'b1;
        end
        S_INIT: begin
          cnt <= cnt + 1'b1;
          if (&cnt) begin
            state     <= S_READY;
            init_busy <= 1'b0;
            init_done <= 1'b1;
          end
        end
        S_READY: begin
          // Write wins over read; the read register holds on any write cycle.
          if (!WE) begin
            if (wr_prot)
              wp_violation <= 1'b1;
          end else if (!OE) begin
            Data_from_SRAM <= in_range ? mem[ADDR[ADDR_W-1:0]] : 16'h0000;
          end
        end
        default: state <= S_RESET;
      endcase
    end
  end

endmodule

// File: tb/tb_slc3_sram_model.sv
// Directed bench for slc3_sram_model with a cycle-level behavioural model.
module tb_slc3_sram_model;
  import slc3_mem_pkg::*;

  localparam int DEPTH = 1024;
  localparam int INITW = 32;
  localparam int PLIM  = 32;
`ifdef SLC3_SRAM_WRITE_PROTECT_EN
  localparam bit WP = 1'b1;
`else
  localparam bit WP = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Reset;
  logic [15:0] ADDR;
  logic        OE, WE;
  logic [15:0] Data_to_SRAM;
  logic [15:0] Data_from_SRAM;
  logic        init_busy, init_done, wp_violation;

  int compared = 0;
  int mismatched = 0;

  slc3_sram_model dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .ADDR           (ADDR),
    .OE             (OE),
    .WE             (WE),
    .Data_to_SRAM   (Data_to_SRAM),
    .Data_from_SRAM (Data_from_SRAM),
    .init_busy      (init_busy),
    .init_done      (init_done),
    .wp_violation   (wp_violation)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: counts edges since reset release; the whole image appears at once
  // when the load window closes, then CPU reads/writes act on a plain array.
  logic [15:0] m_mem [DEPTH];
  logic [15:0] m_dout;
  logic        m_wp;
  int          since;
  bit          valid = 1'b0;

  always @(posedge Clk) begin
    if (!Reset) begin
      valid  = 1'b1;
      since  = 0;
      m_dout = 16'h0000;
      m_wp   = 1'b0;
    end else if (valid) begin
      since++;
      if (since == DEPTH + 1) begin
        for (int i = 0; i < DEPTH; i++)
          m_mem[i] = (i < INITW) ? PROGRAM_IMAGE[i[5:0]] : 16'h0000;
      end else if (since > DEPTH + 1) begin
        if (!WE) begin
          if (ADDR < 16'(DEPTH)) begin
            if (WP && ADDR < 16'(PLIM)) m_wp = 1'b1;
            else m_mem[ADDR[9:0]] = Data_to_SRAM;
          end
        end else if (!OE) begin
          m_dout = (ADDR < 16'(DEPTH)) ? m_mem[ADDR[9:0]] : 16'h0000;
        end
      end
    end
  end

  always @(negedge Clk) begin
    if (valid) begin
      check("m_dout", 32'(Data_from_SRAM), 32'(m_dout));
      check("m_busy", 32'(init_busy), 32'(since >= 1 && since <= DEPTH));
      check("m_done", 32'(init_done), 32'(since > DEPTH));
      check("m_wp",   32'(wp_violation), 32'(m_wp));
    end
  end

  // All stimulus tasks start and end on a falling edge.
  task automatic rd(input logic [15:0] a, input logic [15:0] exp, input string nm);
    ADDR = a; OE = 1'b0; WE = 1'b1;
    @(negedge Clk);
    OE = 1'b1;
    check(nm, 32'(Data_from_SRAM), 32'(exp));
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    ADDR = a; Data_to_SRAM = d; WE = 1'b0; OE = 1'b1;
    @(negedge Clk);
    WE = 1'b1;
  endtask

  task automatic busy_len(input string nm);
    int n;
    n = 0;
    @(negedge Clk);
    while (init_busy === 1'b1 && n < 2000) begin
      n++;
      @(negedge Clk);
    end
    check(nm, 32'(n), 32'd1024);
    check({nm, "_done"}, 32'(init_done), 32'd1);
  endtask

  initial begin
    Reset = 1'b0; OE = 1'b1; WE = 1'b1; ADDR = 16'h0; Data_to_SRAM = 16'h0;
    repeat (3) @(negedge Clk);
    check("rst_dout", 32'(Data_from_SRAM), 32'h0);
    check("rst_busy", 32'(init_busy), 32'd0);
    check("rst_done", 32'(init_done), 32'd0);
    check("rst_wp",   32'(wp_violation), 32'd0);

    Reset = 1'b1;
    busy_len("init_len");

    rd(16'h0000, 16'h5020, "img0");
    rd(16'h0001, 16'h1021, "img1");
    rd(16'h0100, 16'h0000, "zero100");
    rd(16'h001F, 16'hAA55, "img31");
    rd(16'h0020, 16'h0000, "img_cut32");

    wr(16'h0040, 16'hBEEF);
    rd(16'h0040, 16'hBEEF, "wr40");
    ADDR = 16'h0041; Data_to_SRAM = 16'h1234; OE = 1'b0; WE = 1'b0;
    @(negedge Clk);
    OE = 1'b1; WE = 1'b1;
    check("both_low_hold", 32'(Data_from_SRAM), 32'hBEEF);
    rd(16'h0041, 16'h1234, "wr41");

    wr(16'h03FF, 16'h7777);
    wr(16'hFFFF, 16'hAAAA);
    wr(16'h0400, 16'h5555);
    rd(16'hFFFF, 16'h0000, "oor_rd_ffff");
    rd(16'h03FF, 16'h7777, "alias_3ff");
    rd(16'h0400, 16'h0000, "oor_rd_400");
    rd(16'h0000, 16'h5020, "alias_0");
    check("oor_no_wp", 32'(wp_violation), 32'd0);

    wr(16'h0005, 16'hDEAD);
    check("wp_flag", 32'(wp_violation), 32'(WP));
    rd(16'h0005, WP ? 16'h2201 : 16'hDEAD, "wp_word5");
    wr(16'h0020, 16'h4321);
    rd(16'h0020, 16'h4321, "wr20");

    // Reset in the middle of the load, then let it run to completion.
    Reset = 1'b0;
    @(negedge Clk);
    Reset = 1'b1;
    repeat (500) @(negedge Clk);
    check("mid_busy", 32'(init_busy), 32'd1);
    Reset = 1'b0;
    @(negedge Clk);
    check("mid_rst_busy", 32'(init_busy), 32'd0);
    check("mid_rst_wp", 32'(wp_violation), 32'd0);
    Reset = 1'b1;
    busy_len("reinit_len");
    rd(16'h0000, 16'h5020, "re_img0");
    rd(16'h0001, 16'h1021, "re_img1");
    rd(16'h0005, 16'h2201, "re_img5");
    rd(16'h0040, 16'h0000, "re_lost40");
    rd(16'h03FF, 16'h0000, "re_lost3ff");

    repeat (2) @(negedge Clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
